// File: rtl/mc_control_unit_if.sv
// Control-unit bundle: instruction fields and status in, datapath control strobes out.
// The master side is the control FSM; the slave side is the datapath/memory.
interface mc_control_unit_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) ();
    logic [OP_W-1:0] op;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;
    logic            PCWrite_C;
    logic [1:0]      PCSrc;
    logic            BranchCond;
    logic            IRWrite;
    logic            RegWrite;
    logic [1:0]      RegDst;
    logic [1:0]      WrSrc;
    logic            ALUSrcB;
    logic            ExtSel;
    logic [2:0]      ALUOp;
    logic            mRD;
    logic            mWR;
    logic [3:0]      state;
    logic            halted;

    modport master (
        input  op, funct, zero, mem_ready,
        output PCWrite_C, PCSrc, BranchCond, IRWrite, RegWrite, RegDst, WrSrc,
               ALUSrcB, ExtSel, ALUOp, mRD, mWR, state, halted
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  PCWrite_C, PCSrc, BranchCond, IRWrite, RegWrite, RegDst, WrSrc,
               ALUSrcB, ExtSel, ALUOp, mRD, mWR, state, halted
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing with Moore-style controls
// decoded from the op/funct latched when leaving IF.
module mc_control_unit #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic                CLK,
    input  logic                Reset,
    mc_control_unit_if.master   bus
);
    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LW  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'b001000);
    localparam logic [FN_W-1:0] FN_ADD   = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_SUB   = FN_W'(6'b100010);
    localparam logic [FN_W-1:0] FN_AND   = FN_W'(6'b100100);
    localparam logic [FN_W-1:0] FN_OR    = FN_W'(6'b100101);
    localparam logic [FN_W-1:0] FN_SLT   = FN_W'(6'b101010);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    logic [FN_W-1:0] r_funct;

    logic       w_pcw, w_bc, w_irw, w_rw, w_asb, w_ext, w_mrd, w_mwr, w_halted;
    logic [1:0] w_pcsrc, w_regdst, w_wrsrc;
    logic [2:0] w_aluop;
    logic       w_is_r, w_is_jr, w_is_lw;

    assign w_is_r  = (r_op == OP_RTYPE);
    assign w_is_jr = w_is_r && (r_funct == FN_JR);
    assign w_is_lw = (r_op == OP_LW);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IF;
            r_op    <= '0;
            r_funct <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IF) begin
                r_op    <= bus.op;
                r_funct <= bus.funct;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_pcw    = 1'b0;
        w_pcsrc  = 2'b00;
        w_bc     = 1'b0;
        w_irw    = 1'b0;
        w_rw     = 1'b0;
        w_regdst = 2'b00;
        w_wrsrc  = 2'b00;
        w_asb    = 1'b0;
        w_ext    = 1'b0;
        w_aluop  = ALU_ADD;
        w_mrd    = 1'b0;
        w_mwr    = 1'b0;
        w_halted = 1'b0;

        case (r_state)
            S_IF: begin
                w_irw  = 1'b1;
                w_next = S_ID;
            end
            S_ID: begin
                if (r_op == OP_J) begin
                    w_pcw   = 1'b1;
                    w_pcsrc = 2'b10;
                    w_next  = S_IF;
                end else if (r_op == OP_JAL) begin
                    w_pcw    = 1'b1;
                    w_pcsrc  = 2'b10;
                    w_rw     = 1'b1;
                    w_regdst = 2'b10;
                    w_wrsrc  = 2'b10;
                    w_next   = S_IF;
                end else if (w_is_jr) begin
                    w_pcw   = 1'b1;
                    w_pcsrc = 2'b11;
                    w_next  = S_IF;
                end else if (w_is_r || r_op == OP_ADDI || r_op == OP_ORI) begin
                    w_next = S_EXE_AL;
                end else if (r_op == OP_BEQ || r_op == OP_BNE) begin
                    w_next = S_EXE_BR;
                end else if (w_is_lw || r_op == OP_SW) begin
                    w_next = S_EXE_LS;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_EXE_AL: begin
                w_next = S_WB_AL;
                if (w_is_r) begin
                    case (r_funct)
                        FN_ADD:  w_aluop = ALU_ADD;
                        FN_SUB:  w_aluop = ALU_SUB;
                        FN_AND:  w_aluop = ALU_AND;
                        FN_OR:   w_aluop = ALU_OR;
                        FN_SLT:  w_aluop = ALU_SLT;
                        default: w_aluop = ALU_ADD;
                    endcase
                end else if (r_op == OP_ADDI) begin
                    w_asb = 1'b1;
                    w_ext = 1'b1;
                end else begin
                    w_asb   = 1'b1;
                    w_aluop = ALU_OR;
                end
            end
            S_WB_AL: begin
                w_rw     = 1'b1;
                w_regdst = w_is_r ? 2'b01 : 2'b00;
                w_pcw    = 1'b1;
                w_next   = S_IF;
            end
            S_EXE_BR: begin
                w_aluop = ALU_SUB;
                w_pcw   = 1'b1;
                w_pcsrc = 2'b01;
                w_bc    = (r_op == OP_BNE) ? ~bus.zero : bus.zero;
                w_next  = S_IF;
            end
            S_EXE_LS: begin
                w_asb  = 1'b1;
                w_ext  = 1'b1;
                w_next = S_MEM;
            end
            S_MEM: begin
                // Strobes come from the latched opcode so they stay flat through wait cycles.
                w_mrd = w_is_lw;
                w_mwr = ~w_is_lw;
                if (bus.mem_ready) begin
                    if (w_is_lw) begin
                        w_next = S_WB_LW;
                    end else begin
                        w_pcw  = 1'b1;
                        w_next = S_IF;
                    end
                end
            end
            S_WB_LW: begin
                w_rw    = 1'b1;
                w_wrsrc = 2'b01;
                w_pcw   = 1'b1;
                w_next  = S_IF;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: w_next = S_IF;
        endcase

        if (Reset) begin
            w_pcw    = 1'b0;
            w_pcsrc  = 2'b00;
            w_bc     = 1'b0;
            w_irw    = 1'b0;
            w_rw     = 1'b0;
            w_regdst = 2'b00;
            w_wrsrc  = 2'b00;
            w_asb    = 1'b0;
            w_ext    = 1'b0;
            w_aluop  = ALU_ADD;
            w_mrd    = 1'b0;
            w_mwr    = 1'b0;
            w_halted = 1'b0;
        end
    end

    assign bus.PCWrite_C  = w_pcw;
    assign bus.PCSrc      = w_pcsrc;
    assign bus.BranchCond = w_bc;
    assign bus.IRWrite    = w_irw;
    assign bus.RegWrite   = w_rw;
    assign bus.RegDst     = w_regdst;
    assign bus.WrSrc      = w_wrsrc;
    assign bus.ALUSrcB    = w_asb;
    assign bus.ExtSel     = w_ext;
    assign bus.ALUOp      = w_aluop;
    assign bus.mRD        = w_mrd;
    assign bus.mWR        = w_mwr;
    assign bus.halted     = w_halted;
    assign bus.state      = Reset ? 4'd0 : r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed per-cycle vector table for mc_control_unit plus a hand-run lw sequence with wait states.
module tb_mc_control_unit;
    logic CLK;
    logic Reset;

    mc_control_unit_if #(.OP_W(6), .FN_W(6)) bus ();

    mc_control_unit #(.OP_W(6), .FN_W(6)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       nm;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [21:0] ex;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    localparam logic [5:0] DC = 6'h3F;

    // Packed layout: {state, halted, PCWrite_C, PCSrc, BranchCond, IRWrite, RegWrite,
    //                 RegDst, WrSrc, ALUSrcB, ExtSel, ALUOp, mRD, mWR}
    function automatic logic [21:0] e(input logic [3:0] st, input logic pcw, input logic [1:0] ps,
                                      input logic rw, input logic [1:0] rd, input logic [1:0] ws,
                                      input logic asb, input logic ext, input logic [2:0] alu,
                                      input logic bc, input logic mrd, input logic mwr);
        return {st, 1'b0, pcw, ps, bc, 1'b0, rw, rd, ws, asb, ext, alu, mrd, mwr};
    endfunction

    function automatic logic [21:0] eIF();
        return {4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
    endfunction

    function automatic logic [21:0] eZ(input logic [3:0] st);
        return {st, 18'd0};
    endfunction

    function automatic logic [21:0] eH();
        return {4'd8, 1'b1, 17'd0};
    endfunction

    function automatic logic [21:0] eWB(input logic [1:0] rd);
        return e(4'd6, 1'b1, 2'b00, 1'b1, rd, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [21:0] act();
        return {bus.state, bus.halted, bus.PCWrite_C, bus.PCSrc, bus.BranchCond, bus.IRWrite,
                bus.RegWrite, bus.RegDst, bus.WrSrc, bus.ALUSrcB, bus.ExtSel, bus.ALUOp,
                bus.mRD, bus.mWR};
    endfunction

    task automatic v(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [21:0] ex);
        vec_t t;
        t.nm = nm; t.rst = rst; t.op = op; t.fn = fn; t.z = z; t.mr = mr; t.ex = ex;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0] rfn  [6];
    logic [2:0] ralu [6];
    int cyc, memc, pcw_n, mrd_n;
    bit done;

    initial begin
        rfn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        ralu = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};

        v("rst_a", 1, DC, DC, 0, 1, 22'd0);
        v("rst_b", 1, DC, DC, 0, 1, 22'd0);

        for (int k = 0; k < 6; k++) begin
            v($sformatf("r%0d_if", k), 0, 6'h00, rfn[k], 0, 1, eIF());
            v($sformatf("r%0d_id", k), 0, DC, DC, 0, 1, eZ(4'd1));
            v($sformatf("r%0d_ex", k), 0, DC, DC, 0, 1,
              e(4'd2, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, ralu[k], 0, 0, 0));
            v($sformatf("r%0d_wb", k), 0, DC, DC, 0, 1, eWB(2'b01));
        end

        v("addi_if", 0, 6'b001000, DC, 0, 1, eIF());
        v("addi_id", 0, DC, DC, 0, 1, eZ(4'd1));
        v("addi_ex", 0, DC, DC, 0, 1, e(4'd2, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 0));
        v("addi_wb", 0, DC, DC, 0, 1, eWB(2'b00));

        v("ori_if", 0, 6'b001101, DC, 0, 1, eIF());
        v("ori_id", 0, DC, DC, 0, 1, eZ(4'd1));
        v("ori_ex", 0, DC, DC, 0, 1, e(4'd2, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 3'b011, 0, 0, 0));
        v("ori_wb", 0, DC, DC, 0, 1, eWB(2'b00));

        for (int k = 0; k < 4; k++) begin
            logic [5:0] bop;
            logic       zz, bc;
            bop = (k < 2) ? 6'b000100 : 6'b000101;
            zz  = (k % 2 == 0);
            bc  = (k < 2) ? zz : ~zz;
            v($sformatf("br%0d_if", k), 0, bop, DC, zz, 1, eIF());
            v($sformatf("br%0d_id", k), 0, DC, DC, zz, 1, eZ(4'd1));
            v($sformatf("br%0d_ex", k), 0, DC, DC, zz, 1,
              e(4'd3, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 3'b001, bc, 0, 0));
        end

        v("j_if", 0, 6'b000010, DC, 0, 1, eIF());
        v("j_id", 0, DC, DC, 0, 1, e(4'd1, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));
        v("jal_if", 0, 6'b000011, DC, 0, 1, eIF());
        v("jal_id", 0, DC, DC, 0, 1, e(4'd1, 1, 2'b10, 1, 2'b10, 2'b10, 0, 0, 3'b000, 0, 0, 0));
        v("jr_if", 0, 6'b000000, 6'b001000, 0, 1, eIF());
        v("jr_id", 0, DC, DC, 0, 1, e(4'd1, 1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));

        v("sw_if", 0, 6'b101011, DC, 0, 1, eIF());
        v("sw_id", 0, DC, DC, 0, 1, eZ(4'd1));
        v("sw_ls", 0, DC, DC, 0, 1, e(4'd4, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 0));
        v("sw_mem", 0, DC, DC, 0, 1, e(4'd5, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 1));

        v("sww_if", 0, 6'b101011, DC, 0, 0, eIF());
        v("sww_id", 0, DC, DC, 0, 0, eZ(4'd1));
        v("sww_ls", 0, DC, DC, 0, 0, e(4'd4, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 0));
        v("sww_m0", 0, DC, DC, 0, 0, e(4'd5, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 1));
        v("sww_m1", 0, DC, DC, 0, 1, e(4'd5, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 1));

        v("lw_if", 0, 6'b100011, DC, 0, 0, eIF());
        v("lw_id", 0, DC, DC, 0, 0, eZ(4'd1));
        v("lw_ls", 0, DC, DC, 0, 0, e(4'd4, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0, 0, 0));
        v("lw_m0", 0, DC, DC, 0, 0, e(4'd5, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 0));
        v("lw_m1", 0, DC, DC, 0, 0, e(4'd5, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 0));
        v("lw_m2", 0, DC, DC, 0, 1, e(4'd5, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 0));
        v("lw_wb", 0, DC, DC, 0, 1, e(4'd7, 1, 2'b00, 1, 2'b00, 2'b01, 0, 0, 3'b000, 0, 0, 0));

        v("ab_if", 0, 6'h00, 6'b100000, 0, 1, eIF());
        v("ab_id", 0, DC, DC, 0, 1, eZ(4'd1));
        v("ab_ex", 0, DC, DC, 0, 1, eZ(4'd2));
        for (int k = 0; k < 3; k++) v($sformatf("ab_rst%0d", k), 1, DC, DC, 1, 1, 22'd0);
        v("ab_if2", 0, 6'b000010, DC, 0, 1, eIF());
        v("ab_id2", 0, DC, DC, 0, 1, e(4'd1, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));

        v("h1_if", 0, 6'b111111, DC, 0, 1, eIF());
        v("h1_id", 0, 6'h00, 6'h00, 0, 1, eZ(4'd1));
        for (int k = 0; k < 10; k++) v($sformatf("h1_halt%0d", k), 0, 6'h00, 6'h00, 0, 1, eH());
        v("h2_rst", 1, DC, DC, 0, 1, 22'd0);
        v("h2_if", 0, 6'b010101, DC, 0, 1, eIF());
        v("h2_id", 0, 6'h00, 6'h00, 0, 1, eZ(4'd1));
        for (int k = 0; k < 10; k++) v($sformatf("h2_halt%0d", k), 0, 6'h00, 6'h00, 0, 1, eH());

        foreach (tbl[i]) begin
            Reset         = tbl[i].rst;
            bus.op        = tbl[i].op;
            bus.funct     = tbl[i].fn;
            bus.zero      = tbl[i].z;
            bus.mem_ready = tbl[i].mr;
            #1;
            nvec++;
            if (act() !== tbl[i].ex) begin
                nerr++;
                $display("FAIL %s: got %h expected %h", tbl[i].nm, act(), tbl[i].ex);
            end
            @(posedge CLK);
            #2;
        end

        // lw with three wait cycles: the memory is released on the fourth MEM cycle.
        Reset = 1'b1; bus.mem_ready = 1'b0;
        @(posedge CLK); #2;
        Reset = 1'b0; bus.op = 6'b100011; bus.funct = 6'h00;
        cyc = 0; memc = 0; pcw_n = 0; mrd_n = 0; done = 0;
        while (!done && cyc < 40) begin
            #1;
            if (cyc > 0 && bus.state == 4'd0) begin
                done = 1;
            end else begin
                cyc++;
                if (bus.PCWrite_C) pcw_n++;
                if (bus.state == 4'd5) begin
                    memc++;
                    if (bus.mRD) mrd_n++;
                end
                bus.mem_ready = (bus.state == 4'd5) && (memc == 4);
                @(posedge CLK); #2;
                bus.op = DC;
            end
        end
        chk("lw_wait_done", int'(done), 1);
        chk("lw_wait_cycles", cyc, 8);
        chk("lw_wait_pcwrite_pulses", pcw_n, 1);
        chk("lw_wait_mem_cycles", memc, 4);
        chk("lw_wait_mrd_cycles", mrd_n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
